cache_tag_lookup: RTL and testbench
===================================

Name: cache_tag_lookup

Overview:
- Parametrised successor to the cache address splitter. Splits a 32-bit address into tag/index/offset, looks it up in an NUM_WAY-way set-associative tag/valid store and returns hit, hit way and refill victim.
- Sits between the CPU-side request port and the cache data array / refill FSM in both the I- and D-cache.
- Adds behaviour the plain splitter lacks: registered 1-cycle lookup, post-reset valid-clear sweep, refill write, invalidate-by-address, and per-set round-robin victim selection.

Parameters:
- BYTES_PER_LINE, 16, bytes per cache line (power of 2, >=4)
- NUM_LINE, 256, sets per way (power of 2, >=2)
- NUM_WAY, 2, associativity (power of 2, 1..8)
- OFFSET_WIDTH, $clog2(BYTES_PER_LINE), derived
- INDEX_WIDTH, $clog2(NUM_LINE), derived
- TAG_WIDTH, 32-OFFSET_WIDTH-INDEX_WIDTH, derived
- WAY_WIDTH, (NUM_WAY>1 ? $clog2(NUM_WAY) : 1), derived

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  high when lookup accepted this cycle
- req_addr  in  32  lookup address
- resp_valid  out  1  lookup result valid (one cycle after accept)
- resp_hit  out  1  tag matched a valid way
- resp_way  out  WAY_WIDTH  matching way (0 on miss)
- resp_victim  out  WAY_WIDTH  way to replace on miss
- resp_tag / resp_index / resp_offset  out  TAG_WIDTH / INDEX_WIDTH / OFFSET_WIDTH  fields of accepted address
- refill_valid  in  1  write tag into way, set valid
- refill_index  in  INDEX_WIDTH  set to write
- refill_way  in  WAY_WIDTH  way to write
- refill_tag  in  TAG_WIDTH  tag to write
- inv_valid  in  1  invalidate request
- inv_ready  out  1  invalidate accepted this cycle
- inv_addr  in  32  address to invalidate
- init_busy  out  1  valid-clear sweep in progress

Behaviour:
- Field split: index = addr[31-TAG_WIDTH -: INDEX_WIDTH], tag = addr[31 -: TAG_WIDTH], offset = addr[0 +: OFFSET_WIDTH].
- Reset (asynchronous): FSM goes to INIT, sweep counter = 0, all resp_* outputs = 0, req_ready = 0, inv_ready = 0, init_busy = 1. Tag contents are not reset.
- INIT state: each cycle clears the valid bits of all ways at set = counter and resets that set's round-robin pointer to 0; counter increments.
  - Exactly NUM_LINE cycles.
  - After set NUM_LINE-1 is cleared, FSM goes to RUN; init_busy falls on the same edge.
  - Refill and invalidate inputs are ignored in INIT.
  - A reset asserted mid-sweep restarts the sweep from counter 0.
- RUN state: req_ready = 1 unless an invalidate is accepted the same cycle.
  - Accepted request: a registered lookup reads the store; resp_valid = 1 on the next cycle, with all resp_* registered from pre-edge store contents.
  - resp_valid = 0 in any cycle following no accept.
- Hit: resp_hit = 1 and resp_way = lowest-numbered valid way with matching tag. Multiple matching ways are a protocol error; lowest index wins.
- Victim: lowest-numbered invalid way in the set; if all ways are valid, the set's round-robin pointer. Computed for hits too.
- Refill: on refill_valid, writes tag[refill_index][refill_way] and sets valid.
  - Advances the set's pointer to refill_way+1 (mod NUM_WAY).
  - Takes effect at the edge.
  - A lookup accepted in the same cycle to the same set sees the old contents (read-before-write, no bypass).
- Invalidate: accepted only when refill_valid = 0 (inv_ready = 1 that cycle).
  - Clears the valid bit of every way whose tag matches inv_addr's tag in inv_addr's set.
  - The pointer is unchanged.
  - When inv_valid and req_valid are both high, the invalidate wins and req_ready = 0.
  - When inv_valid and refill_valid are both high, the refill wins, inv_ready = 0, and the invalidate retries.
- NUM_WAY = 1: resp_way and resp_victim are always 0; the pointer is unused.

Decomposition:
- Shared package cache_pkg: derived-width localparams/functions (offset/index/tag/way width) and the FSM state encoding (INIT, RUN).
- Field split is reused from the existing address-split module, one instance each for req_addr and inv_addr.
- Natural sub-module: cache_victim_sel (combinational first-invalid / round-robin select from valid vector and pointer).

Test Plan:
- Reset, then hold req_valid = 1 -> req_ready = 0 and init_busy = 1 for exactly 256 cycles (defaults); first accept on cycle 257. Its lookup of 0x1000_0040 gives resp_hit = 0, resp_victim = 0.
- Refill index 0x04, way 1, tag of 0x1000_0040 (0x10000); lookup 0x1000_004C next cycle -> resp_hit = 1, resp_way = 1, resp_offset = 0xC, resp_index = 0x04.
- Refill and lookup of the same set in the same cycle -> that response misses; a lookup one cycle later hits.
- Fill both ways of set 0x04 and refill way 0, then way 1 (pointer wraps to 0) -> a miss to set 0x04 reports resp_victim = 0. After invalidating the way-1 address, resp_victim = 1 and that address misses.
- inv_valid together with refill_valid -> inv_ready = 0 that cycle and refill applied; the invalidate is accepted the next cycle. inv_valid together with req_valid -> req_ready = 0.
- Assert reset at sweep counter 100 after set 0x04 was made valid -> the sweep restarts and lasts 256 cycles; a subsequent lookup of the prior hit address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared field-width helpers and lookup FSM encoding for the cache tag store
package cache_pkg;
    typedef enum logic {INIT, RUN} state_t;
    function automatic int offset_width(input int bytes_per_line);
        return $clog2(bytes_per_line);
    endfunction
    function automatic int index_width(input int num_line);
        return $clog2(num_line);
    endfunction
    function automatic int tag_width(input int bytes_per_line, input int num_line);
        return 32 - $clog2(bytes_per_line) - $clog2(num_line);
    endfunction
    function automatic int way_width(input int num_way);
        return num_way > 1 ? $clog2(num_way) : 1;
    endfunction
endpackage

// File: rtl/cache_tag_lookup_if.sv
// cache_tag_lookup_if: CPU request/response, refill, invalidate and init-status bundle
// slave (tag store): takes req/refill/inv, drives req_ready, resp_*, inv_ready, init_busy
// master (requester): the mirror image
interface cache_tag_lookup_if #(
    parameter int BYTES_PER_LINE = 16,
    parameter int NUM_LINE = 256,
    parameter int NUM_WAY = 2
);
    import cache_pkg::*;
    localparam int OFFSET_WIDTH = offset_width(BYTES_PER_LINE);
    localparam int INDEX_WIDTH = index_width(NUM_LINE);
    localparam int TAG_WIDTH = tag_width(BYTES_PER_LINE, NUM_LINE);
    localparam int WAY_WIDTH = way_width(NUM_WAY);
    logic req_valid, req_ready;
    logic [31:0] req_addr;
    logic resp_valid, resp_hit;
    logic [WAY_WIDTH-1:0] resp_way, resp_victim;
    logic [TAG_WIDTH-1:0] resp_tag;
    logic [INDEX_WIDTH-1:0] resp_index;
    logic [OFFSET_WIDTH-1:0] resp_offset;
    logic refill_valid;
    logic [INDEX_WIDTH-1:0] refill_index;
    logic [WAY_WIDTH-1:0] refill_way;
    logic [TAG_WIDTH-1:0] refill_tag;
    logic inv_valid, inv_ready;
    logic [31:0] inv_addr;
    logic init_busy;
    modport slave (
        input req_valid, req_addr, refill_valid, refill_index, refill_way, refill_tag, inv_valid, inv_addr,
        output req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_tag, resp_index, resp_offset,
        output inv_ready, init_busy
    );
    modport master (
        output req_valid, req_addr, refill_valid, refill_index, refill_way, refill_tag, inv_valid, inv_addr,
        input req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_tag, resp_index, resp_offset,
        input inv_ready, init_busy
    );
endinterface

// File: rtl/cache_addr_split.sv
// cache_addr_split: splits a 32-bit address into tag / index / offset fields
// addr in; tag, index, offset out
module cache_addr_split #(
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH = 20
) (
    input  logic [31:0]             addr,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] offset
);
    assign tag = addr[31 -: TAG_WIDTH];
    assign index = addr[31-TAG_WIDTH -: INDEX_WIDTH];
    assign offset = addr[0 +: OFFSET_WIDTH];
endmodule

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: refill victim = lowest invalid way, else the set's round-robin pointer
// valid, ptr in; victim out
module cache_victim_sel #(
    parameter int NUM_WAY = 2,
    parameter int WAY_WIDTH = 1
) (
    input  logic [NUM_WAY-1:0]   valid,
    input  logic [WAY_WIDTH-1:0] ptr,
    output logic [WAY_WIDTH-1:0] victim
);
    always_comb begin
        victim = NUM_WAY > 1 ? ptr : '0;
        for (int w = NUM_WAY - 1; w >= 0; w--)
            victim = valid[w] ? victim : WAY_WIDTH'(w);
    end
endmodule

// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: set-associative tag/valid store with 1-cycle registered lookup
// clk, reset (async, active-high); bus: slave side of cache_tag_lookup_if
module cache_tag_lookup
    import cache_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int NUM_LINE = 256,
    parameter int NUM_WAY = 2,
    parameter int OFFSET_WIDTH = offset_width(BYTES_PER_LINE),
    parameter int INDEX_WIDTH = index_width(NUM_LINE),
    parameter int TAG_WIDTH = 32 - OFFSET_WIDTH - INDEX_WIDTH,
    parameter int WAY_WIDTH = way_width(NUM_WAY)
) (
    input logic clk,
    input logic reset,
    cache_tag_lookup_if.slave bus
);
    state_t state, state_nxt;
    logic [INDEX_WIDTH-1:0] cnt;
    logic [TAG_WIDTH-1:0] tags [NUM_LINE][NUM_WAY];
    logic [NUM_WAY-1:0] valid [NUM_LINE];
    logic [WAY_WIDTH-1:0] ptr [NUM_LINE];
    logic [TAG_WIDTH-1:0] req_tag, inv_tag, resp_tag;
    logic [INDEX_WIDTH-1:0] req_index, inv_index, resp_index;
    logic [OFFSET_WIDTH-1:0] req_offset, resp_offset;
    logic [NUM_WAY-1:0] match;
    logic [WAY_WIDTH-1:0] hit_way, victim, ptr_nxt, resp_way, resp_victim;
    logic run, inv_acc, req_acc, resp_valid, resp_hit;

    cache_addr_split #(.OFFSET_WIDTH(OFFSET_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_req_split (
        .addr(bus.req_addr), .tag(req_tag), .index(req_index), .offset(req_offset)
    );
    cache_addr_split #(.OFFSET_WIDTH(OFFSET_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_inv_split (
        .addr(bus.inv_addr), .tag(inv_tag), .index(inv_index), .offset()
    );
    cache_victim_sel #(.NUM_WAY(NUM_WAY), .WAY_WIDTH(WAY_WIDTH)) u_victim (
        .valid(valid[req_index]), .ptr(ptr[req_index]), .victim(victim)
    );

    // refill has priority over invalidate, invalidate over lookup
    assign run = state == RUN;
    assign inv_acc = run && bus.inv_valid && !bus.refill_valid;
    assign req_acc = run && !inv_acc && bus.req_valid;
    assign ptr_nxt = NUM_WAY > 1 ? bus.refill_way + 1'b1 : '0;

    assign bus.req_ready = run && !inv_acc;
    assign bus.inv_ready = inv_acc;
    assign bus.init_busy = !run;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_hit = resp_hit;
    assign bus.resp_way = resp_way;
    assign bus.resp_victim = resp_victim;
    assign bus.resp_tag = resp_tag;
    assign bus.resp_index = resp_index;
    assign bus.resp_offset = resp_offset;

    always_comb begin
        state_nxt = state == INIT && cnt == INDEX_WIDTH'(NUM_LINE - 1) ? RUN : state;
        match = '0;
        hit_way = '0;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            match[w] = valid[req_index][w] && tags[req_index][w] == req_tag;
            hit_way = match[w] ? WAY_WIDTH'(w) : hit_way;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt <= '0;
            resp_valid <= 1'b0;
            resp_hit <= 1'b0;
            resp_way <= '0;
            resp_victim <= '0;
            resp_tag <= '0;
            resp_index <= '0;
            resp_offset <= '0;
        end else begin
            state <= state_nxt;
            cnt <= run ? cnt : cnt + 1'b1;
            resp_valid <= req_acc;
            if (req_acc) begin
                resp_hit <= |match;
                resp_way <= hit_way;
                resp_victim <= victim;
                resp_tag <= req_tag;
                resp_index <= req_index;
                resp_offset <= req_offset;
            end
        end
    end

    // tag/valid/pointer store: no reset, the INIT sweep clears valid and pointers
    always_ff @(posedge clk) begin
        if (!run) begin
            valid[cnt] <= '0;
            ptr[cnt] <= '0;
        end else if (bus.refill_valid) begin
            tags[bus.refill_index][bus.refill_way] <= bus.refill_tag;
            valid[bus.refill_index][bus.refill_way] <= 1'b1;
            ptr[bus.refill_index] <= ptr_nxt;
        end else if (inv_acc) begin
            for (int w = 0; w < NUM_WAY; w++)
                if (tags[inv_index][w] == inv_tag) valid[inv_index][w] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_tag_lookup.sv
// tb_cache_tag_lookup: directed table, corner sequences and random traffic against a set/way model
module tb_cache_tag_lookup;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_tag_lookup_if bus();
    cache_tag_lookup dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit rq; logic [31:0] ra;
        bit rf; int rfi; int rfw; int rft;
        bit iv; logic [31:0] ia;
        int e_rr; int e_ir; int e_hit; int e_way; int e_vic;
    } vec_t;
    vec_t tbl[$];

    int n_vec = 0, n_err = 0;
    int m_tag [256][2];
    bit m_val [256][2];
    int m_ptr [256];
    bit m_run;
    int m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rq, input logic [31:0] ra, input bit rf, input int rfi, input int rfw,
                         input int rft, input bit iv, input logic [31:0] ia);
        bus.req_valid = rq;
        bus.req_addr = ra;
        bus.refill_valid = rf;
        bus.refill_index = 8'(rfi);
        bus.refill_way = 1'(rfw);
        bus.refill_tag = 20'(rft);
        bus.inv_valid = iv;
        bus.inv_addr = ia;
    endtask

    // one clock: inputs already applied at the falling edge; model predicts, DUT is compared
    task automatic cycle();
        bit ir, rr, acc;
        int idx, tg, hit, way, vic;
        logic [31:0] a;
        #1;
        ir = m_run && bus.inv_valid && !bus.refill_valid;
        rr = m_run && !ir;
        acc = bus.req_valid && rr;
        chk("init_busy", bus.init_busy, !m_run);
        chk("req_ready", bus.req_ready, rr);
        chk("inv_ready", bus.inv_ready, ir);
        a = bus.req_addr;
        idx = int'(a / 16) % 256;
        tg = int'(a / 4096);
        hit = 0; way = 0; vic = -1;
        for (int w = 0; w < 2; w++) begin
            if (m_val[idx][w] && m_tag[idx][w] == tg && hit == 0) begin hit = 1; way = w; end
            if (!m_val[idx][w] && vic < 0) vic = w;
        end
        if (vic < 0) vic = m_ptr[idx];
        if (!m_run) begin
            m_val[m_cnt][0] = 0; m_val[m_cnt][1] = 0; m_ptr[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == 256) m_run = 1;
        end else if (bus.refill_valid) begin
            m_tag[bus.refill_index][bus.refill_way] = int'(bus.refill_tag);
            m_val[bus.refill_index][bus.refill_way] = 1;
            m_ptr[bus.refill_index] = (int'(bus.refill_way) + 1) % 2;
        end else if (ir) begin
            for (int w = 0; w < 2; w++)
                if (m_tag[int'(bus.inv_addr / 16) % 256][w] == int'(bus.inv_addr / 4096))
                    m_val[int'(bus.inv_addr / 16) % 256][w] = 0;
        end
        @(posedge clk);
        #1;
        chk("resp_valid", bus.resp_valid, acc);
        if (acc) begin
            chk("resp_hit", bus.resp_hit, hit);
            chk("resp_way", bus.resp_way, way);
            chk("resp_victim", bus.resp_victim, vic);
            chk("resp_tag", bus.resp_tag, tg);
            chk("resp_index", bus.resp_index, idx);
            chk("resp_offset", bus.resp_offset, a % 16);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_hit", bus.resp_hit, 0);
        chk("rst_resp_way", bus.resp_way, 0);
        chk("rst_resp_victim", bus.resp_victim, 0);
        chk("rst_resp_tag", bus.resp_tag, 0);
        chk("rst_resp_index", bus.resp_index, 0);
        chk("rst_resp_offset", bus.resp_offset, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_inv_ready", bus.inv_ready, 0);
        chk("rst_init_busy", bus.init_busy, 1);
        m_run = 0;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // hold a lookup of 0x1000_0040 through the sweep; count stalled cycles and check the first response
    task automatic run_init(output int n);
        n = 0;
        drive(1, 32'h1000_0040, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.req_ready) break;
            n++;
            cycle();
        end
        cycle();
        chk("init_len", n, 256);
        chk("first_hit", bus.resp_hit, 0);
        chk("first_victim", bus.resp_victim, 0);
    endtask

    initial begin
        int n;
        tbl.push_back('{0, 32'h0, 1, 4, 1, 'h10000, 0, 32'h0, 1, 0, -1, -1, -1});
        tbl.push_back('{1, 32'h1000_004C, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 32'h2000_0044, 1, 4, 0, 'h20000, 0, 32'h0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h2000_0044, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 1});
        tbl.push_back('{0, 32'h0, 1, 4, 0, 'h20000, 0, 32'h0, 1, 0, -1, -1, -1});
        tbl.push_back('{0, 32'h0, 1, 4, 1, 'h10000, 0, 32'h0, 1, 0, -1, -1, -1});
        tbl.push_back('{1, 32'h3000_0040, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h3000_0040, 0, 0, 0, 0, 1, 32'h1000_0040, 0, 1, -1, -1, -1});
        tbl.push_back('{1, 32'h3000_0040, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1});
        tbl.push_back('{1, 32'h1000_0040, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 32'h0, 1, 4, 1, 'h10000, 1, 32'h2000_0040, 1, 0, -1, -1, -1});
        tbl.push_back('{0, 32'h0, 0, 0, 0, 0, 1, 32'h2000_0040, 0, 1, -1, -1, -1});
        tbl.push_back('{1, 32'h1000_0048, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 32'h2000_0040, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0});

        @(negedge clk);
        apply_reset();
        run_init(n);

        foreach (tbl[i]) begin
            drive(tbl[i].rq, tbl[i].ra, tbl[i].rf, tbl[i].rfi, tbl[i].rfw, tbl[i].rft, tbl[i].iv, tbl[i].ia);
            #1;
            chk($sformatf("tbl%0d_req_ready", i), bus.req_ready, tbl[i].e_rr);
            chk($sformatf("tbl%0d_inv_ready", i), bus.inv_ready, tbl[i].e_ir);
            cycle();
            if (tbl[i].e_hit >= 0) begin
                chk($sformatf("tbl%0d_hit", i), bus.resp_hit, tbl[i].e_hit);
                chk($sformatf("tbl%0d_way", i), bus.resp_way, tbl[i].e_way);
                chk($sformatf("tbl%0d_victim", i), bus.resp_victim, tbl[i].e_vic);
            end
        end

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) << 12) | ($urandom_range(2, 5) << 4) | $urandom_range(0, 15),
                  $urandom_range(0, 4) == 0, $urandom_range(2, 5), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 3) << 12) | ($urandom_range(2, 5) << 4));
            cycle();
        end

        drive(0, 0, 1, 4, 0, 'h10000, 0, 0);
        cycle();
        drive(1, 32'h1000_0040, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("pre_reset_hit", bus.resp_hit, 1);

        apply_reset();
        drive(1, 32'h1000_0040, 0, 0, 0, 0, 0, 0);
        repeat (100) cycle();
        apply_reset();
        run_init(n);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
